// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and a
// counter-width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to hold a count from 0 to w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus between a sequencer and the
// serial adder controller.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/f_adder.sv
// One-bit full adder built from two half adders; purely combinational.
module f_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    h_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    h_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;
endmodule

// File: rtl/h_adder.sv
// One-bit half adder primitive.
module h_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through a
// single shared full-adder cell, with a start/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_s;
    logic             fa_c;

    f_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            // DONE accepts a new start exactly like IDLE, allowing back-to-back issue.
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                sr_d            = sr_q >> 1;
                sr_d[WIDTH-1]   = fa_s;
                carry_d         = fa_c;
                a_d             = a_q >> 1;
                b_d             = b_q >> 1;
                cnt_d           = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = sr_d;
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == ST_ADD);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against an
// arithmetic reference ({cout,sum} = a + b) with cycle-exact handshake timing.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain unsigned addition.
    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Count edges until done (bounded); also counts busy cycles and checks the
    // held result stays put while the addition runs.
    task automatic wait_done8(input string tag, input logic [8:0] held, output int lat,
                              output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!bus8.done && lat < 40) begin
            if (bus8.busy) nbusy++;
            if ({bus8.cout, bus8.sum} !== held) check({tag, "_held"}, {bus8.cout, bus8.sum}, held);
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            tick();
            lat++;
        end
    endtask

    task automatic add8(input string tag, input logic [7:0] x, input logic [7:0] y);
        int          lat;
        int          nbusy;
        logic [8:0]  held;
        held       = {bus8.cout, bus8.sum};
        bus8.start = 1'b1;
        bus8.a     = x;
        bus8.b     = y;
        tick();
        bus8.start = 1'b0;
        wait_done8(tag, held, lat, nbusy);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busy"}, nbusy, 8);
        check({tag, "_res"}, {bus8.cout, bus8.sum}, model8(x, y));
        tick();
        check({tag, "_pulse"}, bus8.done, 1'b0);
    endtask

    initial begin
        int         lat;
        int         nbusy;
        int         ndone;
        logic [7:0] x;
        logic [7:0] y;

        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;

        // Reset held for two edges; all outputs must be low.
        rst = 1'b1;
        tick();
        tick();
        check("rst_out8", {bus8.busy, bus8.done, bus8.cout, bus8.sum}, '0);
        check("rst_out1", {bus1.busy, bus1.done, bus1.cout, bus1.sum}, '0);
        rst = 1'b0;
        tick();

        add8("zero", 8'h00, 8'h00);
        add8("ripple", 8'hFF, 8'h01);
        add8("nocarry", 8'hA5, 8'h5A);

        // Start during ADD is ignored.
        bus8.start = 1'b1;
        bus8.a     = 8'h0F;
        bus8.b     = 8'h01;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        tick();
        bus8.start = 1'b0;
        lat = 3;
        while (!bus8.done && lat < 40) begin
            tick();
            lat++;
        end
        check("ign_lat", lat, 8);
        check("ign_res", {bus8.cout, bus8.sum}, model8(8'h0F, 8'h01));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done) ndone++;
        end
        check("ign_onedone", ndone, 0);

        // Reset mid-ADD aborts with no done and clears the result.
        bus8.start = 1'b1;
        bus8.a     = 8'h80;
        bus8.b     = 8'h80;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {bus8.busy, bus8.done, bus8.cout, bus8.sum}, '0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done || bus8.busy) ndone++;
        end
        check("abort_quiet", ndone, 0);
        add8("post_abort", 8'h03, 8'h04);

        // Back-to-back issue with start held during DONE.
        bus8.start = 1'b1;
        bus8.a     = 8'h01;
        bus8.b     = 8'h02;
        tick();
        bus8.start = 1'b0;
        wait_done8("b2b1", {bus8.cout, bus8.sum}, lat, nbusy);
        check("b2b1_lat", lat, 8);
        check("b2b1_res", {bus8.cout, bus8.sum}, model8(8'h01, 8'h02));
        bus8.start = 1'b1;
        bus8.a     = 8'h10;
        bus8.b     = 8'h20;
        tick();
        bus8.start = 1'b0;
        check("b2b_busy", {bus8.busy, bus8.done}, 2'b10);
        wait_done8("b2b2", model8(8'h01, 8'h02), lat, nbusy);
        check("b2b2_lat", lat, 8);
        check("b2b2_res", {bus8.cout, bus8.sum}, model8(8'h10, 8'h20));
        tick();

        // Random operands, with random idle gaps; result must hold in IDLE.
        for (int i = 0; i < 24; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            add8("rand", x, y);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
            check("rand_hold", {bus8.cout, bus8.sum}, model8(x, y));
        end

        // WIDTH=1: exhaustive over the half-adder truth table.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab         = 2'(i);
            bus1.start = 1'b1;
            bus1.a     = ab[1];
            bus1.b     = ab[0];
            tick();
            bus1.start = 1'b0;
            check("w1_busy", {bus1.busy, bus1.done}, 2'b10);
            lat = 0;
            while (!bus1.done && lat < 10) begin
                tick();
                lat++;
            end
            check("w1_lat", lat, 1);
            check("w1_res", {bus1.cout, bus1.sum}, 2'(ab[1]) + 2'(ab[0]));
            tick();
            check("w1_pulse", bus1.done, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It time-shares one 1-bit full-adder cell, built from two h_adder instances, to add two WIDTH-bit operands over WIDTH cycles, LSB first. A start/done handshake lets an upstream sequencer issue additions without a parallel ripple chain. It is the first sequenced consumer of the h_adder primitive.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 1.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new addition; sampled only on an accepting edge.
a  input  WIDTH  operand A; captured on the accepting edge.
b  input  WIDTH  operand B; captured on the accepting edge.
busy  output  1  high while in ADD.
done  output  1  single-cycle pulse; sum/cout valid.
sum  output  WIDTH  registered result; held until the next accepted start.
cout  output  1  registered carry-out of the MSB; held with sum.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0, carry register=0, bit counter=0, operand shift registers=0.
- Reset has priority over every other event, including mid-ADD: the operation aborts and no done is produced.
- States: IDLE, ADD, DONE.
- IDLE: on start=1, capture a and b into shift registers, clear carry, set count=0, go to ADD. With start=0, stay in IDLE.
- ADD, every edge:
  - Feed the LSBs of the A/B shift registers and the carry register into the full-adder cell.
  - Shift the cell's sum bit into the MSB of the sum shift register (right shift).
  - Carry register <= cell carry-out.
  - Shift both operand registers right; count++.
  - On the edge where count == WIDTH-1, the last bit is processed: load sum/cout with final values and go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted: same actions as from IDLE, next state ADD, so back-to-back issue is allowed.
  - Otherwise go to IDLE.
- start during ADD is ignored; operands are not re-captured.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH. That is WIDTH+1 cycles from the accepting edge, and WIDTH+1 is the minimum accept-to-accept spacing.
- busy = (state==ADD); it is a registered state decode with no combinational path from start.
- sum/cout change only on the final ADD edge and on reset. They are stable in IDLE, and they are not cleared by a new start until that addition finishes.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1); unsigned, no overflow flag.
- WIDTH=1: ADD lasts one edge (count==0 is the last bit).
- Undefined (X) a/b outside the accepting edge has no effect.

Decomposition:
- Shared package serial_add_pkg: state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2. ST 2'd3 is illegal and recovers to IDLE on the next edge.
- One sub-module, f_adder (a, b, cin -> s, cout):
  - two h_adder instances plus an OR of their carries;
  - purely combinational.
- The controller instantiates exactly one f_adder.

Test Plan:
1. WIDTH=8, reset held 2 cycles, then start with a=0x00, b=0x00 -> busy high for 8 cycles, done pulse at cycle 9 after the accepting edge, sum=0x00, cout=0; all outputs 0 during reset.
2. a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple); a=0xA5, b=0x5A -> sum=0xFF, cout=0 (no carries).
3. Start a=0x0F, b=0x01; pulse start again at ADD cycle 3 with a=0xFF, b=0xFF -> ignored; result sum=0x10, cout=0, and only one done pulse.
4. Start a=0x80, b=0x80, then assert rst at ADD cycle 4 -> next cycle IDLE, busy=0, sum=0x00, cout=0, no done pulse; a subsequent start a=0x03, b=0x04 gives sum=0x07.
5. Back-to-back: start a=0x01, b=0x02, and hold start high during DONE with a=0x10, b=0x20 -> done, then busy again immediately; second done after 9 more cycles with sum=0x30. sum=0x03 stays held between the two results.
6. WIDTH=1 build: a=1, b=1 -> done 2 cycles after the accepting edge, sum=0, cout=1; exhaustive over all four input pairs, matching the h_adder truth table.
